// File: rtl/usb_bus_emu.sv
// -----------------------------------------------------------------------------
// usb_bus_emu
//   Simulation-side USB bus model joining NUM_PORTS host ports to NUM_PORTS
//   simulated devices. For each port it resolves D+/D- from both sides'
//   output enables, supplies the pull-up idle (J) level for the port speed,
//   models cable attach with a timed connect, detects host bus reset and
//   optionally counts output-enable conflicts.
//
//   Optional feature macro: USB_BUS_EMU_CONFLICT_CNT_EN
//     defined   : per-port saturating conflict counters plus a console note
//                 on the first cycle of each conflict burst
//     undefined : conflict_cnt_o tied to zero
//
//   Ports (all vectors are one bit per port unless noted):
//     clk, rst_ni                 clock, synchronous active-low reset
//     attach_i                    cable attach request (level)
//     host_dp_o/dm_o/oe           host drive values and output enable
//     host_dp_i/dm_i              resolved levels seen by the host
//     dev_dp_o/dm_o/oe            device drive values and output enable
//     dev_dp_i/dm_i               resolved levels seen by the device
//     attached_o                  port in ATTACHED state
//     bus_reset_o                 host bus reset in progress
//     conflict_cnt_o [8*NUM_PORTS] per-port conflict count, port n at [8n+7:8n]
// -----------------------------------------------------------------------------
module usb_bus_emu #(
   parameter int unsigned          NUM_PORTS        = 2,
   parameter logic [NUM_PORTS-1:0] FULL_SPEED_MASK  = '0,
   parameter int unsigned          CONNECT_DELAY    = 16,
   parameter int unsigned          BUS_RESET_CYCLES = 64
) (
   input  logic                     clk,
   input  logic                     rst_ni,
   input  logic [NUM_PORTS-1:0]     attach_i,
   input  logic [NUM_PORTS-1:0]     host_dp_o,
   input  logic [NUM_PORTS-1:0]     host_dm_o,
   input  logic [NUM_PORTS-1:0]     host_oe,
   output logic [NUM_PORTS-1:0]     host_dp_i,
   output logic [NUM_PORTS-1:0]     host_dm_i,
   input  logic [NUM_PORTS-1:0]     dev_dp_o,
   input  logic [NUM_PORTS-1:0]     dev_dm_o,
   input  logic [NUM_PORTS-1:0]     dev_oe,
   output logic [NUM_PORTS-1:0]     dev_dp_i,
   output logic [NUM_PORTS-1:0]     dev_dm_i,
   output logic [NUM_PORTS-1:0]     attached_o,
   output logic [NUM_PORTS-1:0]     bus_reset_o,
   output logic [8*NUM_PORTS-1:0]   conflict_cnt_o
);

   typedef enum logic [1:0] {
      ST_DETACHED   = 2'd0,
      ST_CONNECTING = 2'd1,
      ST_ATTACHED   = 2'd2
   } state_t;

   localparam logic [15:0] CONN_LAST = 16'(CONNECT_DELAY - 1);
   localparam logic [15:0] RST_LAST  = 16'(BUS_RESET_CYCLES - 1);

   for (genvar n = 0; n < NUM_PORTS; n++) begin : g_port
      localparam logic J_DP = FULL_SPEED_MASK[n];
      localparam logic J_DM = ~FULL_SPEED_MASK[n];

      state_t      state_q, state_d;
      logic [15:0] conn_q, conn_d;
      logic [15:0] se0_q, se0_d;
      logic        brst_q, brst_d;
      logic        att;
      logic        se0_drive;
      logic        h_dp, h_dm, d_dp, d_dm;

      assign att       = (state_q == ST_ATTACHED);
      assign se0_drive = host_oe[n] & ~host_dp_o[n] & ~host_dm_o[n];

      always_ff @(posedge clk) begin
         if (!rst_ni) begin
            state_q <= ST_DETACHED;
            conn_q  <= '0;
            se0_q   <= '0;
            brst_q  <= 1'b0;
         end else begin
            state_q <= state_d;
            conn_q  <= conn_d;
            se0_q   <= se0_d;
            brst_q  <= brst_d;
         end
      end

      always_comb begin
         state_d = state_q;
         conn_d  = conn_q;
         case (state_q)
            ST_DETACHED: begin
               conn_d = '0;
               if (attach_i[n]) state_d = ST_CONNECTING;
            end
            ST_CONNECTING: begin
               if (!attach_i[n]) begin
                  state_d = ST_DETACHED;
                  conn_d  = '0;
               end else if (conn_q == CONN_LAST) begin
                  state_d = ST_ATTACHED;
                  conn_d  = '0;
               end else begin
                  conn_d = conn_q + 16'd1;
               end
            end
            ST_ATTACHED: begin
               if (!attach_i[n]) begin
                  state_d = ST_DETACHED;
                  conn_d  = '0;
               end
            end
            default: begin
               state_d = ST_DETACHED;
               conn_d  = '0;
            end
         endcase
      end

      // SE0 run counter saturates one short of the threshold; the flag is
      // registered so it appears on the edge that samples the final SE0 cycle.
      // A detaching cycle counts as a break so leaving ATTACHED clears both.
      always_comb begin
         se0_d  = '0;
         brst_d = 1'b0;
         if (att && attach_i[n] && se0_drive) begin
            se0_d  = (se0_q == RST_LAST) ? se0_q : se0_q + 16'd1;
            brst_d = (se0_q == RST_LAST);
         end
      end

      always_comb begin
         h_dp = 1'b0;
         h_dm = 1'b0;
         d_dp = 1'b0;
         d_dm = 1'b0;
         if (att) begin
            h_dp = dev_oe[n]  ? dev_dp_o[n]  : J_DP;
            h_dm = dev_oe[n]  ? dev_dm_o[n]  : J_DM;
            d_dp = host_oe[n] ? host_dp_o[n] : J_DP;
            d_dm = host_oe[n] ? host_dm_o[n] : J_DM;
         end
      end

      assign host_dp_i[n]   = h_dp;
      assign host_dm_i[n]   = h_dm;
      assign dev_dp_i[n]    = d_dp;
      assign dev_dm_i[n]    = d_dm;
      assign attached_o[n]  = att;
      assign bus_reset_o[n] = brst_q;

`ifdef USB_BUS_EMU_CONFLICT_CNT_EN
      logic [7:0] cfl_q;
      logic       cfl_prev_q;
      logic       cfl;

      assign cfl = att & host_oe[n] & dev_oe[n];

      always_ff @(posedge clk) begin
         if (!rst_ni) begin
            cfl_q      <= '0;
            cfl_prev_q <= 1'b0;
         end else begin
            if (cfl && (cfl_q != 8'hFF)) cfl_q <= cfl_q + 8'd1;
            cfl_prev_q <= cfl;
            if (cfl && !cfl_prev_q) $display("usb%0d output enable conflict", n);
         end
      end

      assign conflict_cnt_o[8*n +: 8] = cfl_q;
`else
      assign conflict_cnt_o[8*n +: 8] = '0;
`endif
   end

endmodule

// File: tb/tb_usb_bus_emu.sv
module tb_usb_bus_emu;

   localparam int NP  = 2;
   localparam int D   = 16;
   localparam int BR  = 64;
   localparam logic [NP-1:0] MASK = 2'b10;
`ifdef USB_BUS_EMU_CONFLICT_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst_ni;
   logic [NP-1:0]   attach_i, host_dp_o, host_dm_o, host_oe;
   logic [NP-1:0]   dev_dp_o, dev_dm_o, dev_oe;
   logic [NP-1:0]   host_dp_i, host_dm_i, dev_dp_i, dev_dm_i;
   logic [NP-1:0]   attached_o, bus_reset_o;
   logic [8*NP-1:0] conflict_cnt_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   usb_bus_emu #(
      .NUM_PORTS        (NP),
      .FULL_SPEED_MASK  (MASK),
      .CONNECT_DELAY    (D),
      .BUS_RESET_CYCLES (BR)
   ) dut (
      .clk            (clk),
      .rst_ni         (rst_ni),
      .attach_i       (attach_i),
      .host_dp_o      (host_dp_o),
      .host_dm_o      (host_dm_o),
      .host_oe        (host_oe),
      .host_dp_i      (host_dp_i),
      .host_dm_i      (host_dm_i),
      .dev_dp_o       (dev_dp_o),
      .dev_dm_o       (dev_dm_o),
      .dev_oe         (dev_oe),
      .dev_dp_i       (dev_dp_i),
      .dev_dm_i       (dev_dm_i),
      .attached_o     (attached_o),
      .bus_reset_o    (bus_reset_o),
      .conflict_cnt_o (conflict_cnt_o)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 30)
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: attach run length, SE0 run length, conflict tally.
   int run  [NP];
   int srun [NP];
   int ccnt [NP];
   bit mvalid = 1'b0;

   always @(posedge clk) begin
      if (!rst_ni) begin
         for (int n = 0; n < NP; n++) begin
            run[n]  <= 0;
            srun[n] <= 0;
            ccnt[n] <= 0;
         end
         mvalid <= 1'b1;
      end else begin
         for (int n = 0; n < NP; n++) begin
            if (run[n] > D && attach_i[n] && host_oe[n] && !host_dp_o[n] && !host_dm_o[n])
               srun[n] <= srun[n] + 1;
            else
               srun[n] <= 0;
            if (run[n] > D && host_oe[n] && dev_oe[n] && ccnt[n] < 255)
               ccnt[n] <= ccnt[n] + 1;
            if (attach_i[n])
               run[n] <= (run[n] > D) ? run[n] : run[n] + 1;
            else
               run[n] <= 0;
         end
      end
   end

   always @(negedge clk) begin
      logic [NP-1:0]   e_att, e_br, e_hdp, e_hdm, e_ddp, e_ddm;
      logic [8*NP-1:0] e_cnt;
      if (mvalid) begin
         for (int n = 0; n < NP; n++) begin
            e_att[n] = (run[n] > D);
            e_br[n]  = (srun[n] >= BR);
            e_cnt[8*n +: 8] = CNT_EN ? 8'(ccnt[n]) : 8'd0;
            e_hdp[n] = e_att[n] & (dev_oe[n]  ? dev_dp_o[n]  :  MASK[n]);
            e_hdm[n] = e_att[n] & (dev_oe[n]  ? dev_dm_o[n]  : ~MASK[n]);
            e_ddp[n] = e_att[n] & (host_oe[n] ? host_dp_o[n] :  MASK[n]);
            e_ddm[n] = e_att[n] & (host_oe[n] ? host_dm_o[n] : ~MASK[n]);
         end
         chk("model_attached",  32'(attached_o),     32'(e_att));
         chk("model_bus_reset", 32'(bus_reset_o),    32'(e_br));
         chk("model_conflict",  32'(conflict_cnt_o), 32'(e_cnt));
         chk("model_host_dp",   32'(host_dp_i),      32'(e_hdp));
         chk("model_host_dm",   32'(host_dm_i),      32'(e_hdm));
         chk("model_dev_dp",    32'(dev_dp_i),       32'(e_ddp));
         chk("model_dev_dm",    32'(dev_dm_i),       32'(e_ddm));
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1);
   end

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_attached"},  32'(attached_o),     32'd0);
      chk({tag, "_bus_reset"}, 32'(bus_reset_o),    32'd0);
      chk({tag, "_conflict"},  32'(conflict_cnt_o), 32'd0);
      chk({tag, "_host_dpdm"}, 32'({host_dp_i, host_dm_i}), 32'd0);
      chk({tag, "_dev_dpdm"},  32'({dev_dp_i, dev_dm_i}),   32'd0);
   endtask

   initial begin
      rst_ni    = 1'b0;
      attach_i  = '0;
      host_dp_o = '0; host_dm_o = '0; host_oe = '0;
      dev_dp_o  = '0; dev_dm_o  = '0; dev_oe  = '0;

      repeat (2) @(negedge clk);
      chk_reset_vals("reset");

      // Attach both ports: 16 sampled edges still unattached, 17th attaches.
      #1 rst_ni = 1'b1; attach_i = 2'b11;
      repeat (D) @(negedge clk);
      chk("connect_pending", 32'(attached_o), 32'd0);
      chk("connect_pending_dp", 32'({host_dp_i, host_dm_i}), 32'd0);
      @(negedge clk);
      chk("attached", 32'(attached_o), 32'h3);
      chk("idle_host_dp", 32'(host_dp_i), 32'h2);
      chk("idle_host_dm", 32'(host_dm_i), 32'h1);
      chk("idle_dev_dp",  32'(dev_dp_i),  32'h2);

      // Host drives K-ish {1,0} on low-speed port 0.
      #1 host_oe = 2'b01; host_dp_o = 2'b01; host_dm_o = 2'b00;
      #1;
      chk("drive_dev_dp0",  32'(dev_dp_i[0]),  32'd1);
      chk("drive_dev_dm0",  32'(dev_dm_i[0]),  32'd0);
      chk("drive_host_dp0", 32'(host_dp_i[0]), 32'd0);
      chk("drive_host_dm0", 32'(host_dm_i[0]), 32'd1);

      // SE0 for exactly 64 cycles.
      host_dp_o = 2'b00;
      repeat (BR - 1) @(negedge clk);
      chk("busrst_63", 32'(bus_reset_o), 32'd0);
      @(negedge clk);
      chk("busrst_64", 32'(bus_reset_o), 32'd1);
      #1 host_oe = 2'b00;
      @(negedge clk);
      chk("busrst_release", 32'(bus_reset_o), 32'd0);

      // SE0 for 63 cycles never asserts.
      #1 host_oe = 2'b01;
      repeat (BR - 1) @(negedge clk);
      chk("busrst_short", 32'(bus_reset_o), 32'd0);
      #1 host_oe = 2'b00;
      repeat (3) @(negedge clk);
      chk("busrst_short_after", 32'(bus_reset_o), 32'd0);

      // Detach port 0, reconnect with both OEs on; drop at cycle 10.
      #1 attach_i = 2'b10;
      @(negedge clk);
      chk("detach", 32'(attached_o), 32'h2);
      #1 attach_i = 2'b11; host_oe = 2'b01; dev_oe = 2'b01;
      dev_dp_o = 2'b01; host_dp_o = 2'b00; host_dm_o = 2'b01;
      repeat (10) @(negedge clk);
      #1 attach_i = 2'b10;
      @(negedge clk);
      chk("drop_connecting", 32'(attached_o), 32'h2);
      #1 attach_i = 2'b11;
      repeat (D) @(negedge clk);
      chk("reconnect_pending", 32'(attached_o), 32'h2);
      chk("connecting_no_conflict", 32'(conflict_cnt_o), 32'd0);
      @(negedge clk);
      chk("reconnected", 32'(attached_o), 32'h3);
      chk("conflict_host_sees_dev", 32'({host_dp_i[0], host_dm_i[0]}), 32'h2);
      chk("conflict_dev_sees_host", 32'({dev_dp_i[0], dev_dm_i[0]}), 32'h1);

      // Conflict for 300 cycles.
      @(negedge clk);
      chk("conflict_first", 32'(conflict_cnt_o), CNT_EN ? 32'd1 : 32'd0);
      repeat (299) @(negedge clk);
      chk("conflict_sat_p0", 32'(conflict_cnt_o[7:0]), CNT_EN ? 32'd255 : 32'd0);
      chk("conflict_p1", 32'(conflict_cnt_o[15:8]), 32'd0);

      // Bus reset active, then pulse reset.
      #1 dev_oe = 2'b00; host_dp_o = 2'b00; host_dm_o = 2'b00;
      repeat (BR) @(negedge clk);
      chk("busrst_again", 32'(bus_reset_o), 32'd1);
      #1 rst_ni = 1'b0;
      @(negedge clk);
      chk_reset_vals("midreset");
      #1 rst_ni = 1'b1;
      repeat (D) @(negedge clk);
      chk("post_reset_pending", 32'(attached_o), 32'd0);
      @(negedge clk);
      chk("post_reset_attached", 32'(attached_o), 32'h3);
      #1 host_oe = 2'b00;
      repeat (3) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/usb_bus_emu.md
# usb_bus_emu

Simulation-side USB bus model connecting NUM_PORTS USB HID host ports of `top` to NUM_PORTS simulated `top_usb_device` instances inside the sim top-level. It resolves D+/D- per port from both sides' output-enables and models the pull-up/pull-down idle levels per port speed. It also models cable attach/detach with a timed connect, detects host-issued bus reset, and counts output-enable conflicts. It replaces the hard-coded two-port low-speed always_comb bus emulation.

## Interface
- NUM_PORTS, 2, number of independent USB ports (1..8)
- FULL_SPEED_MASK, '0, NUM_PORTS bits; bit n=1: port n idles J as dp=1/dm=0 (full speed), 0: dp=0/dm=1 (low speed)
- CONNECT_DELAY, 16, clk cycles from attach request until pull-up becomes visible (1..65535)
- BUS_RESET_CYCLES, 64, consecutive host-driven SE0 cycles that constitute a bus reset (2..65535)

- clk  in  1  bus model clock, all state on rising edge
- rst_ni  in  1  reset, synchronous, active-low
- attach_i  in  NUM_PORTS  per-port cable attach request, level
- host_dp_o, host_dm_o, host_oe  in  NUM_PORTS each  host-side drive values and output-enable
- host_dp_i, host_dm_i  out  NUM_PORTS each  resolved levels seen by host
- dev_dp_o, dev_dm_o, dev_oe  in  NUM_PORTS each  device-side drive values and output-enable
- dev_dp_i, dev_dm_i  out  NUM_PORTS each  resolved levels seen by device
- attached_o  out  NUM_PORTS  port in ATTACHED state
- bus_reset_o  out  NUM_PORTS  host bus reset in progress (level)
- conflict_cnt_o  out  8*NUM_PORTS  per-port saturating conflict counter, port n at bits [8n+7:8n]

## Operation
- Per-port FSM: DETACHED -> CONNECTING (attach_i=1) -> ATTACHED (connect counter reaches CONNECT_DELAY-1). attach_i=0 in CONNECTING or ATTACHED -> DETACHED next cycle, counter cleared.
- Idle level J(n): FULL_SPEED_MASK[n] ? {dp,dm}=10 : 01.
- DETACHED/CONNECTING: device considered unplugged. host_*_i = host_oe ? SE0 from pull-downs is overridden by nothing, i.e. {0,0}; dev_*_i = {0,0}; dev_oe ignored, never counted as conflict.
- ATTACHED, per {host_oe,dev_oe}: 00 -> both sides see J(n); 01 -> host sees dev drive, device sees J(n); 10 -> device sees host drive, host sees J(n); 11 -> conflict: each side sees the other's drive.
- Bus reset: in ATTACHED, counter increments each cycle host_oe=1 and host drives {0,0}; any other cycle clears it. bus_reset_o asserts when counter reaches BUS_RESET_CYCLES-1, holds until condition breaks; counter saturates.
- Conflict counter (ATTACHED only): +1 per cycle with host_oe=dev_oe=1, saturates at 255, cleared only by reset.
- Leaving ATTACHED clears the bus-reset counter and bus_reset_o; conflict counter retained.

## Timing
- Reset values: FSM DETACHED, all counters 0, attached_o=0, bus_reset_o=0, conflict_cnt_o=0; resolved outputs therefore {0,0} on both sides.
- Resolved dp/dm paths: combinational from *_o/*_oe and registered FSM state, zero latency.
- attach_i rising at edge k -> CONNECTING at k+1 -> attached_o=1 and J visible at k+1+CONNECT_DELAY.
- attach_i falling -> attached_o=0 and SE0 visible one cycle later.
- bus_reset_o rises exactly BUS_RESET_CYCLES cycles after first SE0 cycle is sampled; falls one cycle after the SE0 drive ends.
- conflict_cnt_o updates one cycle after each conflict cycle.
- Reset asserted mid-operation: all ports DETACHED next edge regardless of attach_i; reconnect restarts full CONNECT_DELAY.
- Ports fully independent; no cross-port interaction.

## Configuration
- USB_BUS_EMU_CONFLICT_CNT_EN defined: conflict counters implemented as above, and $display("usbN output enable conflict") printed on each conflict rising edge.
- Not defined: no counter logic, conflict_cnt_o tied to 0, no $display; bus resolution in state 11 unchanged.

## Test plan
- Reset, NUM_PORTS=2, mask=2'b10: attach_i=11 at cycle 0, CONNECT_DELAY=16 -> attached_o=11 at cycle 17; host_dm_i[0]=1/dp=0, host_dp_i[1]=1/dm=0; before that both {0,0}.
- ATTACHED port 0, host_oe=1 drives {dp,dm}=10 -> dev_dp_i[0]=1, dev_dm_i[0]=0 same cycle; host sees J.
- Host drives SE0 for 64 cycles, BUS_RESET_CYCLES=64 -> bus_reset_o[0] rises after 64th cycle; release -> falls next cycle; 63-cycle SE0 -> never asserts.
- host_oe=dev_oe=1 for 300 cycles with macro defined -> conflict_cnt_o[7:0]=255, port 1 count 0; without macro -> 0.
- attach_i[0] dropped at cycle 10 of CONNECTING -> DETACHED, re-attach needs full 16 cycles; dev_oe ignored meanwhile (count unchanged).
- rst_ni low one cycle while ATTACHED with bus_reset_o=1 -> next cycle all outputs at reset values.
